// File: rtl/param_register_file_if.sv
// Register-file access bundle: write, reserve and read-port signals for param_register_file.
// Combinational reads, registered writes and scoreboard; no backpressure.
interface param_register_file_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                     i_wr_en;
  logic [AW-1:0]            i_wr_addr;
  logic [DATA_W-1:0]        i_wr_data;
  logic                     i_rsv_en;
  logic [AW-1:0]            i_rsv_addr;
  logic [NUM_RD*AW-1:0]     i_rd_addr;
  logic [NUM_RD*DATA_W-1:0] o_rd_data;
  logic [NUM_RD-1:0]        o_rd_busy;
  logic [NUM_REGS-1:0]      o_busy_vec;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_rsv_en, i_rsv_addr, i_rd_addr,
    input  o_rd_data, o_rd_busy, o_busy_vec
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_rsv_en, i_rsv_addr, i_rd_addr,
    output o_rd_data, o_rd_busy, o_busy_vec
  );
endinterface

// File: rtl/param_register_file.sv
// Multi-port register file with write-through bypass and a per-register busy scoreboard.
// Reads are 0-cycle combinational, writes/reserves take effect on the next edge; never stalls.
module param_register_file #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  param_register_file_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0]        mem [NUM_REGS];
  logic [NUM_REGS-1:0]      busy;
  logic [NUM_REGS-1:0]      busy_nxt;
  logic                     wr_ok;
  logic                     rsv_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;

  // Addresses that name a real, writable register; the hardwired zero and
  // out-of-range slots are excluded so they never store, bypass or go busy.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = ({1'b0, a} < (AW+1)'(NUM_REGS));
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  assign wr_ok  = bus.i_wr_en  && addr_ok(bus.i_wr_addr);
  assign rsv_ok = bus.i_rsv_en && addr_ok(bus.i_rsv_addr);

  // Reserve is applied after the write clear so it wins on a shared address.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) begin
      busy_nxt[bus.i_wr_addr] = 1'b0;
    end
    if (rsv_ok) begin
      busy_nxt[bus.i_rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
      busy <= '0;
    end else begin
      if (wr_ok) begin
        mem[bus.i_wr_addr] <= bus.i_wr_data;
      end
      busy <= busy_nxt;
    end
  end

  // Read ports: outputs are forced low while reset is asserted so a
  // pending write cannot leak through the bypass path.
  always_comb begin
    logic [AW-1:0] a;
    logic          hit;
    rd_data = '0;
    rd_busy = '0;
    a       = '0;
    hit     = 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      a   = bus.i_rd_addr[p*AW +: AW];
      hit = wr_ok && (bus.i_wr_addr == a);
      if (i_rst_n && addr_ok(a)) begin
        rd_data[p*DATA_W +: DATA_W] = hit ? bus.i_wr_data : mem[a];
        rd_busy[p]                  = busy[a] && !hit;
      end
    end
  end

  assign bus.o_rd_data  = rd_data;
  assign bus.o_rd_busy  = rd_busy;
  assign bus.o_busy_vec = busy;
endmodule
